// File: rtl/counter_palindrome_axil_sequencer.sv
// Single-command AXI4-Lite master: one local command becomes one AXI4-Lite write or read, answered by a
// one-cycle response pulse. A per-state watchdog aborts a stalled handshake with response 2'b11.
module counter_palindrome_axil_sequencer #(
   parameter int C_ADDR_WIDTH = 4,
   parameter int C_TIMEOUT    = 255
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [C_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]             cmd_wdata,
   output logic                    rsp_valid,
   output logic [31:0]             rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic [C_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic                    M_AXI_AWVALID,
   input  logic                    M_AXI_AWREADY,
   output logic [31:0]             M_AXI_WDATA,
   output logic                    M_AXI_WVALID,
   input  logic                    M_AXI_WREADY,
   input  logic [1:0]              M_AXI_BRESP,
   input  logic                    M_AXI_BVALID,
   output logic                    M_AXI_BREADY,
   output logic [C_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                    M_AXI_ARVALID,
   input  logic                    M_AXI_ARREADY,
   input  logic [31:0]             M_AXI_RDATA,
   input  logic [1:0]              M_AXI_RRESP,
   input  logic                    M_AXI_RVALID,
   output logic                    M_AXI_RREADY
);
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WADDR_DATA = 3'd1,
      S_WRESP      = 3'd2,
      S_RADDR      = 3'd3,
      S_RDATA      = 3'd4,
      S_DONE       = 3'd5
   } state_e;

   localparam logic [7:0] TIMEOUT_LAST = 8'(C_TIMEOUT - 1);
   localparam logic [1:0] RESP_TIMEOUT = 2'b11;

   state_e                  state_q;
   logic [7:0]              timer_q;
   logic                    cmd_ready_q;
   logic                    rsp_valid_q;
   logic [31:0]             rsp_rdata_q;
   logic [1:0]              rsp_resp_q;
   logic [C_ADDR_WIDTH-1:0] awaddr_q;
   logic [C_ADDR_WIDTH-1:0] araddr_q;
   logic [31:0]             wdata_q;
   logic                    awvalid_q;
   logic                    wvalid_q;
   logic                    bready_q;
   logic                    arvalid_q;
   logic                    rready_q;
   logic                    timeout_s;
   logic                    aw_done_s;
   logic                    w_done_s;
   logic                    addr_lsb_unused_s;

   assign timeout_s         = (timer_q == TIMEOUT_LAST);
   assign aw_done_s         = !awvalid_q || M_AXI_AWREADY;
   assign w_done_s          = !wvalid_q || M_AXI_WREADY;
   assign addr_lsb_unused_s = ^cmd_addr[1:0];

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

   // Sequencer FSM with registered bus and response outputs; timer restarts on every state change.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= S_IDLE;
         timer_q     <= 8'd0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_resp_q  <= 2'b00;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= 32'd0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
      end else begin
         timer_q <= timer_q + 8'd1;
         case (state_q)
            S_IDLE: begin
               timer_q <= 8'd0;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  if (cmd_write) begin
                     awaddr_q  <= {cmd_addr[C_ADDR_WIDTH-1:2], 2'b00};
                     wdata_q   <= cmd_wdata;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_WADDR_DATA;
                  end else begin
                     araddr_q  <= {cmd_addr[C_ADDR_WIDTH-1:2], 2'b00};
                     arvalid_q <= 1'b1;
                     state_q   <= S_RADDR;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_WADDR_DATA: begin
               if (aw_done_s && w_done_s) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  timer_q   <= 8'd0;
                  state_q   <= S_WRESP;
               end else if (timeout_s) begin
                  awvalid_q   <= 1'b0;
                  wvalid_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_resp_q  <= RESP_TIMEOUT;
                  rsp_rdata_q <= 32'd0;
                  timer_q     <= 8'd0;
                  state_q     <= S_DONE;
               end else begin
                  // AW and W retire independently; each valid drops after its own handshake
                  if (awvalid_q && M_AXI_AWREADY) begin
                     awvalid_q <= 1'b0;
                  end else begin
                     awvalid_q <= awvalid_q;
                  end
                  if (wvalid_q && M_AXI_WREADY) begin
                     wvalid_q <= 1'b0;
                  end else begin
                     wvalid_q <= wvalid_q;
                  end
               end
            end
            S_WRESP: begin
               if (M_AXI_BVALID) begin
                  bready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_resp_q  <= M_AXI_BRESP;
                  rsp_rdata_q <= 32'd0;
                  timer_q     <= 8'd0;
                  state_q     <= S_DONE;
               end else if (timeout_s) begin
                  bready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_resp_q  <= RESP_TIMEOUT;
                  rsp_rdata_q <= 32'd0;
                  timer_q     <= 8'd0;
                  state_q     <= S_DONE;
               end else begin
                  state_q <= S_WRESP;
               end
            end
            S_RADDR: begin
               if (M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  timer_q   <= 8'd0;
                  state_q   <= S_RDATA;
               end else if (timeout_s) begin
                  arvalid_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_resp_q  <= RESP_TIMEOUT;
                  rsp_rdata_q <= 32'd0;
                  timer_q     <= 8'd0;
                  state_q     <= S_DONE;
               end else begin
                  state_q <= S_RADDR;
               end
            end
            S_RDATA: begin
               if (M_AXI_RVALID) begin
                  rready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_resp_q  <= M_AXI_RRESP;
                  rsp_rdata_q <= M_AXI_RDATA;
                  timer_q     <= 8'd0;
                  state_q     <= S_DONE;
               end else if (timeout_s) begin
                  rready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_resp_q  <= RESP_TIMEOUT;
                  rsp_rdata_q <= 32'd0;
                  timer_q     <= 8'd0;
                  state_q     <= S_DONE;
               end else begin
                  state_q <= S_RDATA;
               end
            end
            S_DONE: begin
               rsp_valid_q <= 1'b0;
               rsp_resp_q  <= 2'b00;
               rsp_rdata_q <= 32'd0;
               cmd_ready_q <= 1'b1;
               timer_q     <= 8'd0;
               state_q     <= S_IDLE;
            end
            default: begin
               awvalid_q   <= 1'b0;
               wvalid_q    <= 1'b0;
               bready_q    <= 1'b0;
               arvalid_q   <= 1'b0;
               rready_q    <= 1'b0;
               rsp_valid_q <= 1'b0;
               cmd_ready_q <= 1'b1;
               timer_q     <= 8'd0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_counter_palindrome_axil_sequencer.sv
// Bench for counter_palindrome_axil_sequencer: a 4-register AXI4-Lite slave with programmable ready/response
// delays, plus an array model of the register file that predicts every response.
module tb_counter_palindrome_axil_sequencer;
   localparam int AW = 4;
   localparam int TO = 16;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
   logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [31:0]   M_AXI_WDATA, M_AXI_RDATA;
   logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
   logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic          M_AXI_RVALID, M_AXI_RREADY;

   counter_palindrome_axil_sequencer #(.C_ADDR_WIDTH(AW), .C_TIMEOUT(TO)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_fail   = 0;

   // slave configuration (main process) and slave state (slave process)
   int         cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
   bit         cfg_no_ar;
   logic [1:0] cfg_resp;
   bit         aw_have, w_have, ar_have, b_done, r_done;
   int         aw_wait, w_wait, b_wait, ar_wait, r_wait;
   int         aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
   logic [3:0] aw_addr_cap, ar_addr_cap;
   logic [31:0] w_data_cap;
   logic [31:0] slv_mem [4];

   // reference model state and results of the last command
   logic [31:0] ref_mem [4];
   int          last_lat, last_awv, last_wv, last_arv, last_both1;
   logic [31:0] last_rdata;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic slv_clear();
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'd0; M_AXI_RRESP = 2'b00;
      aw_have = 1'b0; w_have = 1'b0; ar_have = 1'b0; b_done = 1'b0; r_done = 1'b0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      for (int i = 0; i < 4; i++) slv_mem[i] = 32'd0;
   endtask

   // AXI4-Lite slave: observe handshakes at posedge, drive ready/valid at negedge
   initial begin
      slv_clear();
      forever begin
         @(posedge ACLK);
         if (ARESETN) begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_have = 1'b1; aw_addr_cap = M_AXI_AWADDR; aw_hs++; end
            if (M_AXI_WVALID && M_AXI_WREADY) begin w_have = 1'b1; w_data_cap = M_AXI_WDATA; w_hs++; end
            if (M_AXI_BVALID && M_AXI_BREADY) begin b_done = 1'b1; b_hs++; end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_have = 1'b1; ar_addr_cap = M_AXI_ARADDR; ar_hs++; end
            if (M_AXI_RVALID && M_AXI_RREADY) begin r_done = 1'b1; r_hs++; end
         end
         @(negedge ACLK);
         if (!ARESETN) begin
            slv_clear();
         end else begin
            if (b_done) begin
               M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
               aw_have = 1'b0; w_have = 1'b0; b_done = 1'b0; aw_wait = 0; w_wait = 0; b_wait = 0;
            end
            if (r_done) begin
               M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'd0; M_AXI_RRESP = 2'b00;
               ar_have = 1'b0; r_done = 1'b0; ar_wait = 0; r_wait = 0;
            end
            if (M_AXI_AWVALID && !aw_have) begin
               if (aw_wait >= cfg_aw_dly) M_AXI_AWREADY = 1'b1;
               else begin M_AXI_AWREADY = 1'b0; aw_wait++; end
            end else M_AXI_AWREADY = 1'b0;
            if (M_AXI_WVALID && !w_have) begin
               if (w_wait >= cfg_w_dly) M_AXI_WREADY = 1'b1;
               else begin M_AXI_WREADY = 1'b0; w_wait++; end
            end else M_AXI_WREADY = 1'b0;
            if (M_AXI_ARVALID && !ar_have && !cfg_no_ar) begin
               if (ar_wait >= cfg_ar_dly) M_AXI_ARREADY = 1'b1;
               else begin M_AXI_ARREADY = 1'b0; ar_wait++; end
            end else M_AXI_ARREADY = 1'b0;
            if (aw_have && w_have && !M_AXI_BVALID) begin
               if (b_wait >= cfg_b_dly) begin
                  M_AXI_BVALID = 1'b1; M_AXI_BRESP = cfg_resp;
                  slv_mem[aw_addr_cap[3:2]] = w_data_cap;
               end else b_wait++;
            end
            if (ar_have && !M_AXI_RVALID) begin
               if (r_wait >= cfg_r_dly) begin
                  M_AXI_RVALID = 1'b1; M_AXI_RDATA = slv_mem[ar_addr_cap[3:2]]; M_AXI_RRESP = cfg_resp;
               end else r_wait++;
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      check_val({tag, ":cmd_ready"}, 32'(cmd_ready), 32'd1);
      check_val({tag, ":ctl"}, 32'({rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                   M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
      check_val({tag, ":data"}, rsp_rdata | M_AXI_WDATA, 32'd0);
      check_val({tag, ":addr_resp"}, 32'({rsp_resp, M_AXI_AWADDR, M_AXI_ARADDR}), 32'd0);
   endtask

   // one command end to end; expectations come from ref_mem and the configured slave response
   task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                         input logic [1:0] resp_cfg, input bit to, input string tag);
      int          n, idx, ready_hi, awv, wv, arv, both1;
      int          aw0, w0, b0, ar0, r0, hs_wr, hs_rd;
      bit          got;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      cfg_resp = resp_cfg;
      if (to) begin
         exp_resp = 2'b11; exp_rdata = 32'd0;
      end else if (wr) begin
         ref_mem[addr[3:2]] = data; exp_resp = resp_cfg; exp_rdata = 32'd0;
      end else begin
         exp_resp = resp_cfg; exp_rdata = ref_mem[addr[3:2]];
      end
      aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
      @(negedge ACLK);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
      check_val({tag, ":ready"}, 32'(cmd_ready), 32'd1);
      @(negedge ACLK);
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = 32'd0;
      idx = 1; got = 1'b0; ready_hi = 0; awv = 0; wv = 0; arv = 0; both1 = 0;
      while (!got && idx < 100) begin
         if (rsp_valid) got = 1'b1;
         else begin
            if (cmd_ready) ready_hi++;
            if (M_AXI_AWVALID) awv++;
            if (M_AXI_WVALID) wv++;
            if (M_AXI_ARVALID) arv++;
            if (idx == 1 && M_AXI_AWVALID && M_AXI_WVALID) both1 = 1;
            idx++;
            @(negedge ACLK);
         end
      end
      check_val({tag, ":rsp_seen"}, 32'(got), 32'd1);
      check_val({tag, ":resp"}, 32'(rsp_resp), 32'(exp_resp));
      check_val({tag, ":rdata"}, rsp_rdata, exp_rdata);
      check_val({tag, ":busy_ready"}, 32'(ready_hi + 32'(cmd_ready)), 32'd0);
      check_val({tag, ":bus_idle_at_rsp"}, 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                              M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
      last_lat = idx; last_awv = awv; last_wv = wv; last_arv = arv; last_both1 = both1;
      last_rdata = rsp_rdata;
      @(negedge ACLK);
      check_val({tag, ":pulse_ready"}, 32'({rsp_valid, cmd_ready}), 32'b01);
      hs_wr = (aw_hs - aw0) * 100 + (w_hs - w0) * 10 + (b_hs - b0);
      hs_rd = (ar_hs - ar0) * 10 + (r_hs - r0);
      check_val({tag, ":hs_wr"}, 32'(hs_wr), wr ? 32'd111 : 32'd0);
      check_val({tag, ":hs_rd"}, 32'(hs_rd), (wr || to) ? 32'd0 : 32'd11);
      if (wr) check_val({tag, ":awaddr"}, 32'(aw_addr_cap), 32'({addr[3:2], 2'b00}));
      else if (!to) check_val({tag, ":araddr"}, 32'(ar_addr_cap), 32'({addr[3:2], 2'b00}));
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit got=expired exp=finish");
      $fatal(1, "time limit");
   end

   initial begin
      int n, rsp_seen;
      ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = 32'd0;
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
      cfg_no_ar = 1'b0; cfg_resp = 2'b00;
      for (int i = 0; i < 4; i++) ref_mem[i] = 32'd0;
      repeat (3) @(negedge ACLK);
      check_reset("reset");
      ARESETN = 1'b1;

      do_cmd(1'b1, 4'h0, 32'h1, 2'b00, 1'b0, "zw_wr");
      check_val("zw_wr_latency", 32'(last_lat), 32'd3);
      check_val("zw_wr_awv_cycles", 32'(last_awv), 32'd1);
      check_val("zw_wr_wv_cycles", 32'(last_wv), 32'd1);
      check_val("zw_wr_aw_w_together", 32'(last_both1), 32'd1);

      for (int i = 0; i < 4; i++) do_cmd(1'b1, 4'(i * 4), 32'(i + 1), 2'b00, 1'b0, "seq_wr");
      for (int i = 0; i < 4; i++) begin
         do_cmd(1'b0, 4'(i * 4), 32'd0, 2'b00, 1'b0, "seq_rd");
         check_val("seq_rd_value", last_rdata, 32'(i + 1));
         if (i == 0) check_val("zw_rd_latency", 32'(last_lat), 32'd3);
      end

      cfg_w_dly = 3;
      do_cmd(1'b1, 4'h8, 32'hA5A5_0001, 2'b00, 1'b0, "w_late");
      cfg_w_dly = 0; cfg_aw_dly = 3;
      do_cmd(1'b1, 4'hC, 32'h5A5A_0002, 2'b00, 1'b0, "aw_late");
      cfg_aw_dly = 0;

      do_cmd(1'b0, 4'h7, 32'd0, 2'b00, 1'b0, "unaligned_rd");
      check_val("unaligned_rd_value", last_rdata, 32'd2);

      cfg_no_ar = 1'b1;
      do_cmd(1'b0, 4'h4, 32'd0, 2'b00, 1'b1, "timeout_rd");
      check_val("timeout_arvalid_cycles", 32'(last_arv), 32'(TO));
      cfg_no_ar = 1'b0;

      for (int k = 0; k < 40; k++) begin
         cfg_aw_dly = int'($urandom_range(0, 5)); cfg_w_dly = int'($urandom_range(0, 5));
         cfg_b_dly  = int'($urandom_range(0, 5)); cfg_ar_dly = int'($urandom_range(0, 5));
         cfg_r_dly  = int'($urandom_range(0, 5));
         do_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00, 1'b0, "rand");
      end
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;

      // abandon a write while it waits for B
      cfg_b_dly = 6; cfg_resp = 2'b00;
      @(negedge ACLK);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'hDEAD_BEEF;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
      @(negedge ACLK);
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = 32'd0;
      n = 0;
      while (!M_AXI_BREADY && n < 50) begin @(negedge ACLK); n++; end
      check_val("midreset_in_wresp", 32'(M_AXI_BREADY), 32'd1);
      ARESETN = 1'b0;
      #1;
      check_reset("midreset");
      rsp_seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge ACLK);
         if (c == 2) ARESETN = 1'b1;
         if (rsp_valid) rsp_seen++;
      end
      check_val("midreset_no_rsp", 32'(rsp_seen), 32'd0);
      for (int i = 0; i < 4; i++) ref_mem[i] = 32'd0;
      cfg_b_dly = 0;
      do_cmd(1'b1, 4'hC, 32'h1234_5678, 2'b00, 1'b0, "post_rst_wr");
      do_cmd(1'b0, 4'hC, 32'd0, 2'b00, 1'b0, "post_rst_rd");
      check_val("post_rst_rd_value", last_rdata, 32'h1234_5678);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/counter_palindrome_axil_sequencer.md
# counter_palindrome_axil_sequencer

Single-command AXI4-Lite master that sequences register accesses into the CounterPalindrome 4-register AXI4-Lite slave on behalf of local control logic. It accepts one command at a time on a valid/ready port, runs the matching AXI4-Lite write or read, and returns a one-cycle response pulse. A watchdog aborts hung transactions. It sits between the local controller and the slave's S00_AXI port.

## Interface
- C_ADDR_WIDTH, 4: AXI byte-address width; 4 registers at 0x0/0x4/0x8/0xC.
- C_TIMEOUT, 255: cycles a handshake may stall before abort, 1..255.
- ACLK  in  1  clock.
- ARESETN  in  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_ADDR_WIDTH  byte address; bits [1:0] forced to 0 on the bus.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_resp  out  2  BRESP/RRESP; 2'b11 = timeout.
- M_AXI_AWADDR  out  C_ADDR_WIDTH  write address.
- M_AXI_AWVALID  out  1  write-address valid.
- M_AXI_AWREADY  in  1  write-address ready.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WVALID  out  1  write-data valid.
- M_AXI_WREADY  in  1  write-data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write-response valid.
- M_AXI_BREADY  out  1  write-response ready.
- M_AXI_ARADDR  out  C_ADDR_WIDTH  read address.
- M_AXI_ARVALID  out  1  read-address valid.
- M_AXI_ARREADY  in  1  read-address ready.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read-data valid.
- M_AXI_RREADY  out  1  read-data ready.
- AWPROT/ARPROT are tied to 3'b000 and WSTRB to 4'hF at integration; they are not ports of this block.

## Operation
- FSM states: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/wdata/write and go to WADDR_DATA (write) or RADDR (read).
- WADDR_DATA: AWVALID and WVALID both assert in the same cycle. Each drops independently after its own ready is seen, so AW and W may complete in either order or together. When both are done, go to WRESP.
- WRESP: BREADY=1. On BVALID, latch BRESP and go to DONE.
- RADDR: ARVALID=1 until ARREADY, then go to RDATA.
- RDATA: RREADY=1. On RVALID, latch RDATA/RRESP and go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then return to IDLE.
- Watchdog: an 8-bit counter clears on every state entry and increments each cycle in WADDR_DATA/WRESP/RADDR/RDATA. On reaching C_TIMEOUT: deassert all VALID/READY, set rsp_resp=2'b11, rsp_rdata=0, go to DONE. Late B/R beats that arrive after a timeout are ignored while in IDLE; BREADY/RREADY stay 0 outside their states.
- Address and data outputs hold stable while their VALID is high (AXI rule). VALID never depends combinationally on READY.

## Timing
- Reset (async assert, sync release): state IDLE, cmd_ready=1, every other output 0, counter 0.
- Reset mid-transaction: the transaction is abandoned and no rsp_valid is issued.
- Best-case latency, cmd accept to rsp_valid: write 4 cycles (accept, AW+W, B, DONE); read 4 cycles (accept, AR, R, DONE).
- cmd_ready is low from the cycle after acceptance until the cycle after DONE. There is one outstanding command at most.
- All outputs are registered.

## Test plan
- Write 0x00000001 to 0x0 with a zero-wait slave -> AWVALID/WVALID together for 1 cycle, rsp_valid 4 cycles after accept, rsp_resp=2'b00.
- Writes 1..4 to 0x0,0x4,0x8,0xC, then read back all four -> rsp_rdata = 1,2,3,4 in order.
- WREADY delayed 3 cycles after AWREADY, then the reverse ordering -> exactly one AW and one W handshake each, single response.
- cmd_addr=0x7 -> M_AXI_ARADDR=0x4.
- Slave never asserts ARREADY, C_TIMEOUT=16 -> ARVALID drops, rsp_resp=2'b11, rsp_rdata=0, back in IDLE.
- ARESETN pulsed low during WRESP -> all outputs 0 and no rsp_valid; the next command completes normally.
